// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter, the execute stage and the memory tile:
// arbiter state encoding and memory access size codes.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    localparam logic [2:0] CMD_BYTE  = 3'd1;
    localparam logic [2:0] CMD_DWORD = 3'b010;
    localparam logic [2:0] CMD_QWORD = 3'd4;

    // Instruction fetches only ever use the low 32 bits of a memory beat.
    function automatic logic [31:0] fetchWord(input logic [63:0] beat);
        return beat[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the fetch port, data port and memory-side bus around the arbiter.
// slave is the arbiter's view; master is the requesters plus memory.
interface mem_port_arb_if;

    logic        ifReq;
    logic [47:0] ifAddr;
    logic        ifOk;
    logic [31:0] ifData;
    logic        ifErr;

    logic        dReq;
    logic        dWr;
    logic [2:0]  dCmd;
    logic [47:0] dAddr;
    logic [63:0] dWrData;
    logic        dOk;
    logic [63:0] dRdData;
    logic        dErr;

    logic        memRd;
    logic        memWr;
    logic [2:0]  memCmd;
    logic [47:0] memAddr;
    logic [63:0] memWrValue;
    logic [63:0] memRdValue;
    logic        memOk;

    modport slave (
        input  ifReq, ifAddr, dReq, dWr, dCmd, dAddr, dWrData, memRdValue, memOk,
        output ifOk, ifData, ifErr, dOk, dRdData, dErr,
               memRd, memWr, memCmd, memAddr, memWrValue
    );

    modport master (
        output ifReq, ifAddr, dReq, dWr, dCmd, dAddr, dWrData, memRdValue, memOk,
        input  ifOk, ifData, ifErr, dOk, dRdData, dErr,
               memRd, memWr, memCmd, memAddr, memWrValue
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired rises once TIMEOUT cycles have passed.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] waitCnt;

    assign expired = (waitCnt == CW'(TIMEOUT));

    // Held at zero outside an access so each access starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            waitCnt <= '0;
        end else if (!expired) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates one memory port between instruction fetch and data accesses.
// Data wins unless fetch has been passed over STARVE_MAX times in a row.
import mem_port_arb_pkg::*;

module mem_port_arb #(
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_port_arb_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arbState_t     state;
    logic [SW-1:0] starveCnt;
    logic [63:0]   rdBuf;
    logic          accErr;
    logic          respFetch;
    logic          inAcc;
    logic          dataGrant;
    logic          waitExpired;

    assign inAcc     = (state == ACC_I) || (state == ACC_D);
    assign dataGrant = bus.dReq && !(bus.ifReq && (starveCnt == STARVE_LIM));

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) uWaitTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (inAcc),
        .expired (waitExpired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            starveCnt      <= '0;
            rdBuf          <= '0;
            accErr         <= 1'b0;
            respFetch      <= 1'b0;
            bus.memRd      <= 1'b0;
            bus.memWr      <= 1'b0;
            bus.memCmd     <= '0;
            bus.memAddr    <= '0;
            bus.memWrValue <= '0;
            bus.ifOk       <= 1'b0;
            bus.ifErr      <= 1'b0;
            bus.ifData     <= '0;
            bus.dOk        <= 1'b0;
            bus.dErr       <= 1'b0;
            bus.dRdData    <= '0;
        end else begin
            bus.ifOk  <= 1'b0;
            bus.ifErr <= 1'b0;
            bus.dOk   <= 1'b0;
            bus.dErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dataGrant) begin
                        bus.memCmd     <= bus.dCmd;
                        bus.memAddr    <= bus.dAddr;
                        bus.memWrValue <= bus.dWrData;
                        bus.memWr      <= bus.dWr;
                        bus.memRd      <= !bus.dWr;
                        // Only count grants that actually made a fetch wait.
                        if (!bus.ifReq) begin
                            starveCnt <= '0;
                        end else if (starveCnt != STARVE_LIM) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
                        state <= ACC_D;
                    end else if (bus.ifReq) begin
                        bus.memCmd     <= CMD_DWORD;
                        bus.memAddr    <= bus.ifAddr;
                        bus.memWrValue <= '0;
                        bus.memWr      <= 1'b0;
                        bus.memRd      <= 1'b1;
                        starveCnt      <= '0;
                        state          <= ACC_I;
                    end
                end
                ACC_I, ACC_D: begin
                    // memOk wins over a timeout landing on the same cycle.
                    if (bus.memOk || waitExpired) begin
                        rdBuf     <= bus.memOk ? bus.memRdValue : 64'd0;
                        accErr    <= !bus.memOk;
                        respFetch <= (state == ACC_I);
                        bus.memRd <= 1'b0;
                        bus.memWr <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (respFetch) begin
                        bus.ifOk   <= 1'b1;
                        bus.ifErr  <= accErr;
                        bus.ifData <= fetchWord(rdBuf);
                    end else begin
                        bus.dOk     <= 1'b1;
                        bus.dErr    <= accErr;
                        bus.dRdData <= rdBuf;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 2, meaning the maximum consecutive data grants while a fetch is pending.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for memOk before forced completion.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset_n, input, 1, the reset; reset is synchronous and active-low.
REQ-005 The block SHALL have port ifReq, input, 1, instruction-fetch request, level, held until ifOk.
REQ-006 The block SHALL have port ifAddr, input, 48, fetch address; fetch is always a DWORD read.
REQ-007 The block SHALL have port ifOk, output, 1, one-cycle fetch completion pulse.
REQ-008 The block SHALL have port ifData, output, 32, fetched word, valid while ifOk=1 and held until the next fetch completes.
REQ-009 The block SHALL have ports dReq (input, 1) and dWr (input, 1): data request level held until dOk; dWr=1 selects store.
REQ-010 The block SHALL have ports dCmd (input, 3), dAddr (input, 48) and dWrData (input, 64): access size code, address and store data.
REQ-011 The block SHALL have ports dOk (output, 1), dRdData (output, 64) and dErr (output, 1): completion pulse, load data, and timeout flag valid with dOk.
REQ-012 The block SHALL have port ifErr, output, 1, timeout flag valid with ifOk.
REQ-013 The block SHALL have memory-side ports memRd (output, 1), memWr (output, 1), memCmd (output, 3), memAddr (output, 48), memWrValue (output, 64), memRdValue (input, 64) and memOk (input, 1, access-complete strobe).

Function
REQ-014 The state machine SHALL have states IDLE, ACC_I, ACC_D and RESP.
REQ-015 In IDLE with a request pending, the block SHALL grant and register the memory outputs, then enter ACC_I or ACC_D on the next edge.
REQ-016 The block SHALL grant dReq over ifReq unless starveCnt==STARVE_MAX and ifReq=1, in which case it SHALL grant fetch.
REQ-017 starveCnt SHALL increment on each data grant made while ifReq=1, clear on each fetch grant or when ifReq=0 at grant time, and saturate at STARVE_MAX.
REQ-018 For a fetch grant the block SHALL drive memCmd=DWORD code (3'b010), memRd=1, memWr=0 and memAddr=ifAddr.
REQ-019 For a data grant the block SHALL drive memCmd=dCmd, memAddr=dAddr, memWrValue=dWrData, memWr=dWr and memRd=!dWr.
REQ-020 memRd, memWr, memCmd, memAddr and memWrValue SHALL stay stable throughout ACC_x and SHALL be deasserted (strobes=0) on entry to RESP.
REQ-021 In ACC_x, memOk=1 SHALL capture memRdValue (fetch keeps bits 31:0), set err=0 and move to RESP.
REQ-022 In ACC_x, a wait counter reaching TIMEOUT without memOk SHALL move to RESP with err=1, and the read data SHALL be captured as 0.
REQ-023 In RESP the block SHALL pulse exactly one of ifOk/dOk for one cycle, with the matching err flag, and return to IDLE.
REQ-024 Latency: with memOk in the first ACC cycle, the request sampled at edge N SHALL produce Ok high in the cycle after edge N+2; minimum occupancy is 3 cycles per access.
REQ-025 The block SHALL ignore request inputs outside IDLE; the requester SHALL NOT change Addr, Cmd or WrData while its Req is high.
REQ-026 memOk SHALL be ignored while in IDLE or RESP.
REQ-027 With no request pending, the block SHALL stay in IDLE with all strobes 0.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, starveCnt=0 and the wait counter to 0.
REQ-029 While reset_n=0 at a clock edge, the block SHALL set memRd, memWr, ifOk, dOk, ifErr and dErr to 0.
REQ-030 While reset_n=0 at a clock edge, the block SHALL set memCmd, memAddr, memWrValue, ifData and dRdData to 0.
REQ-031 A reset mid-access SHALL abort the access without an Ok pulse, and the requester SHALL re-issue after reset.

Structure
REQ-032 The state encoding and the memCmd size codes (BYTE=1, WORD=2 as DWORD 3'b010, QWORD=4) SHALL reside in a shared package also used by the execute stage and the memory tile.
REQ-033 The block SHALL be a single module; the timeout counter MAY be a sub-module mem_wait_timer.

Verification
REQ-034 The bench SHALL drive a lone ifReq with addr 0x1000 and memOk one cycle after the strobe, and SHALL see memRd=1 with memCmd=3'b010, then ifOk with ifData=memRdValue[31:0], in 4 cycles.
REQ-035 The bench SHALL assert ifReq and dReq (load) in the same cycle, and SHALL see the data access served first and the fetch served next.
REQ-036 The bench SHALL hold dReq continuously with ifReq pending and STARVE_MAX=2, and SHALL see the grant order D, D, I, D, D, I.
REQ-037 The bench SHALL issue a store dAddr=0x2008 with dWrData=0xDEADBEEF_01234567 and dCmd=4, and SHALL see memWr=1 with the values stable until memOk, then dOk=1 and dErr=0.
REQ-038 The bench SHALL never assert memOk, and SHALL see dOk with dErr=1 and dRdData=0 after TIMEOUT+2 cycles.
REQ-039 The bench SHALL assert reset_n=0 during ACC_D, and SHALL see strobes at 0, no dOk pulse and state IDLE on the next edge.
